// File: rtl/hc_tx_pkg.sv
// Shared constants for the HC Tx port responder: requester indices, Tx control codes
// and the two-state grant FSM encoding.
package hc_tx_pkg;

    localparam int DEFAULT_NUM_REQ    = 3;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    localparam int REQ_DIRECT = 0;
    localparam int REQ_SOF    = 1;
    localparam int REQ_PKT    = 2;

    localparam logic [7:0] TX_CNTL_LINE_STATE = 8'h00;
    localparam logic [7:0] TX_CNTL_RESUME_END = 8'h05;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/hc_tx_port_responder_if.sv
// Requester-facing Req/Gnt/Rdy/WEn/Data/Cntl bundle plus the SIE-facing FIFO head.
// slave = responder side, master = requesters/SIE side.
interface hc_tx_port_responder_if #(
    parameter int NUM_REQ    = 3,
    parameter int FIFO_DEPTH = 4
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            wen;
    logic [8*NUM_REQ-1:0]          data;
    logic [8*NUM_REQ-1:0]          cntl;
    logic [NUM_REQ-1:0]            gnt;
    logic                          rdy;
    logic                          out_valid;
    logic [7:0]                    out_data;
    logic [7:0]                    out_cntl;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          protocol_err;

    modport slave (
        input  req, wen, data, cntl, out_ready,
        output gnt, rdy, out_valid, out_data, out_cntl, fifo_count, protocol_err
    );

    modport master (
        output req, wen, data, cntl, out_ready,
        input  gnt, rdy, out_valid, out_data, out_cntl, fifo_count, protocol_err
    );
endinterface

// File: rtl/hc_tx_fifo.sv
// Synchronous FIFO; count is one bit wider than the pointers so full and empty differ.
// A push while full is only taken when a pop frees the slot in the same cycle.
module hc_tx_fifo #(
    parameter int   WIDTH = 16,
    parameter int   DEPTH = 4,
    localparam int  PW    = $clog2(DEPTH),
    localparam int  CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CW'(1'b0));
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/hc_tx_port_responder.sv
// Responder for the HC Tx port: fixed-priority grant (index 0 highest, no preemption),
// Rdy pacing with a two-slot margin, {cntl,data} FIFO toward the SIE, sticky protocol error.
module hc_tx_port_responder
    import hc_tx_pkg::*;
#(
    parameter int  NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input logic                  clk,
    input logic                  rst,
    hc_tx_port_responder_if.slave bus
);
    tx_state_e          state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               err_q;
    logic               err_d;
    logic [NUM_REQ-1:0] pick_s;
    logic [15:0]        wr_data_s;
    logic [15:0]        rd_data_s;
    logic [CW-1:0]      count_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               illegal_wen_s;

    // Lowest set request index wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        pick_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pick_s = NUM_REQ'(1'b1) << i;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Grant FSM: a dropped request returns to IDLE, forcing a one-cycle gap before the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q   <= pick_s;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (~|(bus.req & gnt_q)) begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-select mux driven by the registered one-hot grant.
    always_comb begin
        wr_data_s = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                wr_data_s = {bus.cntl[8*i +: 8], bus.data[8*i +: 8]};
            end else begin
                wr_data_s = wr_data_s;
            end
        end
    end

    assign push_s        = |(bus.wen & gnt_q);
    assign illegal_wen_s = |(bus.wen & ~gnt_q);
    assign pop_s         = ~empty_s & bus.out_ready;
    assign err_d         = err_q | illegal_wen_s | (push_s & full_s & ~pop_s);

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    hc_tx_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wr_data_i (wr_data_s),
        .rd_data_o (rd_data_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .count_o   (count_s)
    );

    // Rdy keeps two free slots so a write issued one cycle after sampling Rdy still fits.
    assign bus.rdy          = (state_q == ST_GRANT) && (count_s <= CW'(FIFO_DEPTH - 2));
    assign bus.gnt          = gnt_q;
    assign bus.out_valid    = ~empty_s;
    assign bus.out_data     = rd_data_s[7:0];
    assign bus.out_cntl     = rd_data_s[15:8];
    assign bus.fifo_count   = count_s;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_hc_tx_port_responder.sv
// Directed self-checking bench for hc_tx_port_responder: grant, contention, backpressure,
// streaming, illegal write and reset-mid-grant scenarios with hand-computed expectations.
module tb_hc_tx_port_responder;
    import hc_tx_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hc_tx_port_responder_if #(.NUM_REQ(3), .FIFO_DEPTH(4)) bus ();

    hc_tx_port_responder #(.NUM_REQ(3), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 3'b000;
        bus.wen = 3'b000;
        bus.data = 24'h000000;
        bus.cntl = 24'h000000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.gnt !== 3'b000) begin
            n_errors++; $display("FAIL reset_gnt: got %b want 000", bus.gnt);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_errors++; $display("FAIL reset_fifo: got valid=%b count=%0d want 0/0", bus.out_valid, bus.fifo_count);
        end
        n_checks++;
        if (bus.protocol_err !== 1'b0 || bus.rdy !== 1'b0) begin
            n_errors++; $display("FAIL reset_err_rdy: got err=%b rdy=%b want 0/0", bus.protocol_err, bus.rdy);
        end
    endtask

    task automatic test_single();
        bus.req = 3'b010;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b010 || bus.rdy !== 1'b1) begin
            n_errors++; $display("FAIL single_gnt: got gnt=%b rdy=%b want 010/1", bus.gnt, bus.rdy);
        end
        bus.wen = 3'b010;
        bus.data[15:8] = 8'h02;
        bus.cntl[15:8] = TX_CNTL_LINE_STATE;
        tick();
        bus.wen = 3'b000;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02 || bus.out_cntl !== 8'h00 || bus.fifo_count !== 3'd1) begin
            n_errors++; $display("FAIL single_push: got v=%b d=%h c=%h n=%0d want 1/02/00/1",
                                 bus.out_valid, bus.out_data, bus.out_cntl, bus.fifo_count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_errors++; $display("FAIL single_pop: got v=%b n=%0d want 0/0", bus.out_valid, bus.fifo_count);
        end
        bus.req = 3'b000;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.rdy !== 1'b0) begin
            n_errors++; $display("FAIL single_drop: got gnt=%b rdy=%b want 000/0", bus.gnt, bus.rdy);
        end
    endtask

    task automatic test_contention();
        bus.req = 3'b110;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b010) begin
            n_errors++; $display("FAIL cont_first: got %b want 010", bus.gnt);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 3'b010) begin
            n_errors++; $display("FAIL cont_hold: got %b want 010", bus.gnt);
        end
        bus.req = 3'b100;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b000) begin
            n_errors++; $display("FAIL cont_gap: got %b want 000", bus.gnt);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 3'b100) begin
            n_errors++; $display("FAIL cont_second: got %b want 100", bus.gnt);
        end
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d;
        bus.out_ready = 1'b0;
        bus.req = 3'b001;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.rdy !== (k < 3)) begin
                n_errors++; $display("FAIL bp_rdy[%0d]: got %b want %b", k, bus.rdy, (k < 3));
            end
            bus.wen = 3'b001;
            bus.data[7:0] = 8'h10 + 8'(k);
            bus.cntl[7:0] = TX_CNTL_RESUME_END;
            tick();
            bus.wen = 3'b000;
            n_checks++;
            if (bus.fifo_count !== 3'(k + 1)) begin
                n_errors++; $display("FAIL bp_count[%0d]: got %0d want %0d", k, bus.fifo_count, k + 1);
            end
        end
        n_checks++;
        if (bus.protocol_err !== 1'b0 || bus.rdy !== 1'b0) begin
            n_errors++; $display("FAIL bp_full: got err=%b rdy=%b want 0/0", bus.protocol_err, bus.rdy);
        end
        // push and pop together while full
        bus.wen = 3'b001;
        bus.data[7:0] = 8'h14;
        bus.out_ready = 1'b1;
        tick();
        bus.wen = 3'b000;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.protocol_err !== 1'b0 || bus.out_data !== 8'h11) begin
            n_errors++; $display("FAIL bp_pushpop: got n=%0d err=%b d=%h want 4/0/11",
                                 bus.fifo_count, bus.protocol_err, bus.out_data);
        end
        bus.wen = 3'b001;
        bus.data[7:0] = 8'hEE;
        tick();
        bus.wen = 3'b000;
        n_checks++;
        if (bus.fifo_count !== 3'd4 || bus.protocol_err !== 1'b1) begin
            n_errors++; $display("FAIL bp_overflow: got n=%0d err=%b want 4/1", bus.fifo_count, bus.protocol_err);
        end
        tick();
        n_checks++;
        if (bus.out_data !== 8'h11 || bus.out_cntl !== 8'h05) begin
            n_errors++; $display("FAIL bp_stable: got d=%h c=%h want 11/05", bus.out_data, bus.out_cntl);
        end
        bus.req = 3'b000;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = 8'h11 + 8'(k);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
                n_errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want 1/%h", k, bus.out_valid, bus.out_data, exp_d);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.protocol_err !== 1'b1) begin
            n_errors++; $display("FAIL bp_empty: got n=%0d v=%b err=%b want 0/0/1",
                                 bus.fifo_count, bus.out_valid, bus.protocol_err);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_d;
        bus.req = 3'b100;
        tick();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_d = 8'hA0 + 8'(k);
            n_checks++;
            if (bus.rdy !== 1'b1) begin
                n_errors++; $display("FAIL stream_rdy[%0d]: got %b want 1", k, bus.rdy);
            end
            bus.wen = 3'b100;
            bus.data[23:16] = exp_d;
            bus.cntl[23:16] = TX_CNTL_LINE_STATE;
            tick();
            bus.wen = 3'b000;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.fifo_count !== 3'd1) begin
                n_errors++; $display("FAIL stream_data[%0d]: got v=%b d=%h n=%0d want 1/%h/1",
                                     k, bus.out_valid, bus.out_data, bus.fifo_count, exp_d);
            end
            tick();
            n_checks++;
            if (bus.fifo_count !== 3'd0) begin
                n_errors++; $display("FAIL stream_drain[%0d]: got %0d want 0", k, bus.fifo_count);
            end
        end
        bus.out_ready = 1'b0;
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_illegal();
        bus.req = 3'b010;
        tick();
        bus.wen = 3'b001;
        bus.data[7:0] = 8'h55;
        tick();
        bus.wen = 3'b000;
        n_checks++;
        if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.protocol_err !== 1'b1) begin
            n_errors++; $display("FAIL illegal_wen: got n=%0d v=%b err=%b want 0/0/1",
                                 bus.fifo_count, bus.out_valid, bus.protocol_err);
        end
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        bus.req = 3'b010;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.wen = 3'b010;
            bus.data[15:8] = 8'h30 + 8'(k);
            tick();
        end
        bus.wen = 3'b100;
        tick();
        bus.wen = 3'b000;
        n_checks++;
        if (bus.fifo_count !== 3'd2 || bus.gnt !== 3'b010 || bus.protocol_err !== 1'b1) begin
            n_errors++; $display("FAIL midrst_pre: got n=%0d gnt=%b err=%b want 2/010/1",
                                 bus.fifo_count, bus.gnt, bus.protocol_err);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.protocol_err !== 1'b0) begin
            n_errors++; $display("FAIL midrst_post: got gnt=%b v=%b n=%0d err=%b want 000/0/0/0",
                                 bus.gnt, bus.out_valid, bus.fifo_count, bus.protocol_err);
        end
        rst = 1'b0;
        bus.req = 3'b000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        do_reset();
        test_streaming();
        test_illegal();
        do_reset();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
